// File: rtl/spi_slave_regfile_pkg.sv
// Shared constants for the SPI register file: FSM encoding and command bit positions.
// Optional burst auto-increment is enabled with SPI_REGFILE_AUTOINC_EN.
package spi_slave_regfile_pkg;

  localparam logic [0:0] ST_CMD  = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  function automatic int wr_bit(input int dw);
    return dw - 1;
  endfunction

  function automatic int burst_bit(input int dw);
    return dw - 2;
  endfunction

endpackage

// File: rtl/spi_slave_regfile.sv
// Command/data parser and register array behind an SPI word interface stage.
// Define SPI_REGFILE_AUTOINC_EN to enable burst auto-increment of the address.
module spi_slave_regfile
  import spi_slave_regfile_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int ADDR_W            = 3,
  localparam int DW               = 2 ** SPI_MAX_WIDTH_LOG,
  localparam int NREG             = 2 ** ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_start,
  input  logic                 spi_finish,
  input  logic [DW-1:0]        spi_rx_data,
  output logic [DW-1:0]        spi_tx_data,
  input  logic                 frame_abort,
  input  logic                 loc_we,
  input  logic [ADDR_W-1:0]    loc_addr,
  input  logic [DW-1:0]        loc_wdata,
  output logic [DW*NREG-1:0]   reg_flat,
  output logic                 wr_strobe,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic                 collision
);

  localparam int WB = wr_bit(DW);
  localparam int BB = burst_bit(DW);

  logic [0:0]        r_state;
  logic              r_op;
  logic              r_burst;
  logic [ADDR_W-1:0] r_addr;
  logic [DW-1:0]     r_regs [NREG];

  logic              w_cmd_fin;
  logic              w_dat_fin;
  logic              w_spi_we;
  logic              w_burst_cmd;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_unused;

  // spi_start only marks word boundaries; tx is already stable by then
  assign w_unused    = spi_start;
  assign w_cmd_fin   = spi_finish && !frame_abort && (r_state == ST_CMD);
  assign w_dat_fin   = spi_finish && !frame_abort && (r_state == ST_DATA);
  assign w_spi_we    = w_dat_fin && r_op;
  assign w_cmd_addr  = spi_rx_data[ADDR_W-1:0];
  assign w_next_addr = r_addr + ADDR_W'(1);

`ifdef SPI_REGFILE_AUTOINC_EN
  assign w_burst_cmd = spi_rx_data[BB];
`else
  assign w_burst_cmd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CMD;
      r_op        <= 1'b0;
      r_burst     <= 1'b0;
      r_addr      <= '0;
      spi_tx_data <= '0;
    end else if (frame_abort) begin
      r_state     <= ST_CMD;
      spi_tx_data <= '0;
    end else if (w_cmd_fin) begin
      r_state     <= ST_DATA;
      r_op        <= spi_rx_data[WB];
      r_burst     <= w_burst_cmd;
      r_addr      <= w_cmd_addr;
      spi_tx_data <= spi_rx_data[WB] ? '0 : r_regs[w_cmd_addr];
    end else if (w_dat_fin) begin
      if (r_burst) begin
        r_addr      <= w_next_addr;
        spi_tx_data <= r_op ? '0 : r_regs[w_next_addr];
      end else begin
        r_state     <= ST_CMD;
        spi_tx_data <= '0;
      end
    end
  end

  // SPI write is applied last so it wins over a local write to the same address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (loc_we) begin
        r_regs[loc_addr] <= loc_wdata;
      end
      if (w_spi_we) begin
        r_regs[r_addr] <= spi_rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      collision <= 1'b0;
    end else begin
      wr_strobe <= w_spi_we;
      collision <= w_spi_we && loc_we;
      if (w_spi_we) begin
        wr_addr <= r_addr;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign reg_flat[g*DW +: DW] = r_regs[g];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed and randomized check of spi_slave_regfile against a word-level model.
// Burst expectations follow SPI_REGFILE_AUTOINC_EN when it is defined.
module tb_spi_slave_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         spi_start;
  logic         spi_finish;
  logic [15:0]  spi_rx_data;
  logic [15:0]  spi_tx_data;
  logic         frame_abort;
  logic         loc_we;
  logic [2:0]   loc_addr;
  logic [15:0]  loc_wdata;
  logic [127:0] reg_flat;
  logic         wr_strobe;
  logic [2:0]   wr_addr;
  logic         collision;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_regs [8];
  bit          m_in_data;
  bit          m_op;
  bit          m_burst;
  logic [2:0]  m_addr;
  logic [15:0] m_tx;

`ifdef SPI_REGFILE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  spi_slave_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_start   (spi_start),
    .spi_finish  (spi_finish),
    .spi_rx_data (spi_rx_data),
    .spi_tx_data (spi_tx_data),
    .frame_abort (frame_abort),
    .loc_we      (loc_we),
    .loc_addr    (loc_addr),
    .loc_wdata   (loc_wdata),
    .reg_flat    (reg_flat),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int i = 0; i < 8; i++) f[i*16 +: 16] = m_regs[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_in_data = 0;
    m_op      = 0;
    m_burst   = 0;
    m_addr    = '0;
    m_tx      = '0;
  endtask

  // One SPI word: start pulse, hold check, finish pulse with optional
  // coincident abort and local write, then compare against the model.
  task automatic word(input logic [15:0] rx, input bit abort, input bit lwe,
                      input logic [2:0] la, input logic [15:0] lwd);
    bit          sw;
    logic [2:0]  swa;
    logic [15:0] old [8];
    @(negedge clk);
    spi_start = 1'b1;
    @(negedge clk);
    spi_start = 1'b0;
    chk("strobe_idle", wr_strobe, 1'b0);
    chk("tx_after_start", spi_tx_data, m_tx);
    repeat (2) @(negedge clk);
    chk("tx_hold", spi_tx_data, m_tx);
    spi_finish  = 1'b1;
    spi_rx_data = rx;
    frame_abort = abort;
    loc_we      = lwe;
    loc_addr    = la;
    loc_wdata   = lwd;
    @(negedge clk);
    spi_finish  = 1'b0;
    frame_abort = 1'b0;
    loc_we      = 1'b0;
    old = m_regs;
    sw  = 0;
    swa = '0;
    if (abort) begin
      m_in_data = 0;
      m_tx      = '0;
    end else if (!m_in_data) begin
      m_in_data = 1;
      m_op      = rx[15];
      m_burst   = AUTOINC && rx[14];
      m_addr    = rx[2:0];
      m_tx      = m_op ? 16'h0 : old[m_addr];
    end else begin
      if (m_op) begin
        sw  = 1;
        swa = m_addr;
      end
      if (m_burst) begin
        m_addr = m_addr + 3'd1;
        m_tx   = m_op ? 16'h0 : old[m_addr];
      end else begin
        m_in_data = 0;
        m_tx      = '0;
      end
    end
    if (lwe) m_regs[la] = lwd;
    if (sw) m_regs[swa] = rx;
    chk("wr_strobe", wr_strobe, sw);
    if (sw) chk("wr_addr", wr_addr, swa);
    if (!lwe || !sw || la == swa) chk("collision", collision, lwe && sw);
    chk("tx_after_finish", spi_tx_data, m_tx);
    chk("reg_flat", reg_flat, m_flat());
  endtask

  task automatic w(input logic [15:0] rx);
    word(rx, 1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", spi_tx_data, 16'h0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 3'd0);
    chk("rst_collision", collision, 1'b0);
    chk("rst_regs", reg_flat, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    rst_n       = 1'b0;
    spi_start   = 1'b0;
    spi_finish  = 1'b0;
    spi_rx_data = '0;
    frame_abort = 1'b0;
    loc_we      = 1'b0;
    loc_addr    = '0;
    loc_wdata   = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_regs", reg_flat, 128'h0);
    chk("reset_tx", spi_tx_data, 16'h0);
    rst_n = 1'b1;

    // Basic write and read-back
    w(16'h8003);
    w(16'hBEEF);
    chk("reg3_beef", reg_flat[3*16 +: 16], 16'hBEEF);
    w(16'h0003);
    chk("read_tx_beef", spi_tx_data, 16'hBEEF);
    w(16'h0000);
    chk("read_tx_cleared", spi_tx_data, 16'h0);

    // Same-address collision: SPI wins
    w(16'h8003);
    word(16'h5555, 1'b0, 1'b1, 3'd3, 16'h1234);
    chk("collide_reg3", reg_flat[3*16 +: 16], 16'h5555);

    // Different-address local write alongside SPI write
    w(16'h8005);
    word(16'h6666, 1'b0, 1'b1, 3'd6, 16'h4321);

    // Abort on the data word
    w(16'h8002);
    word(16'h7777, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("abort_reg2", reg_flat[2*16 +: 16], 16'h0);
    w(16'h0003);
    chk("abort_back_in_cmd", spi_tx_data, 16'h5555);
    w(16'h0000);

    // Burst write with address wrap
    w(16'hC007);
    w(16'h000A);
    w(16'h000B);
    chk("burst_reg7", reg_flat[7*16 +: 16], 16'h000A);
    chk("burst_reg0", reg_flat[0 +: 16], AUTOINC ? 16'h000B : 16'h0000);
    word(16'h0000, 1'b1, 1'b0, 3'd0, 16'h0);

    // Reset between command and data
    w(16'h8001);
    do_reset();
    w(16'h8004);
    w(16'h1111);
    chk("post_reset_reg1", reg_flat[16 +: 16], 16'h0);
    chk("post_reset_reg4", reg_flat[4*16 +: 16], 16'h1111);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [15:0] rx;
      bit          ab;
      bit          lw;
      rx = 16'($urandom);
      ab = ($urandom_range(0, 9) == 0);
      lw = ($urandom_range(0, 3) == 0);
      word(rx, ab, lw, 3'($urandom), 16'($urandom));
    end
    word(16'h0000, 1'b1, 1'b0, 3'd0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
